pfd_lock_controller: RTL and testbench

//  Sequences the PFD-based reference-clock discipline loop: presets the VCXO, closes the loop,

---
 rtl/pfd_lock_controller.sv | 192 +++++++++++++++++++
 tb/tb_pfd_lock_controller.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pfd_lock_controller.sv
// PFD lock sequencer: presets the VCXO, closes the loop, qualifies lock over whole
// compare periods, and retries or faults when lock cannot be held.
module pfd_lock_controller #(
    parameter logic [15:0] LOCK_TICKS   = 16'd64,
    parameter logic [15:0] UNLOCK_TICKS = 16'd4,
    parameter logic [15:0] ACQ_TIMEOUT  = 16'd2000,
    parameter logic [15:0] PRESET_TICKS = 16'd100,
    parameter logic [15:0] HOLD_TICKS   = 16'd500,
    parameter logic [3:0]  MAX_RETRY    = 4'd7
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       enable_i,
    input  logic       ref_tick_i,
    input  logic       lock_n_i,
    output logic       loop_enable_o,
    output logic       vcxo_preset_o,
    output logic       locked_o,
    output logic       fault_o,
    output logic [2:0] state_o,
    output logic [3:0] retry_count_o
);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StPreset   = 3'd1,
        StAcquire  = 3'd2,
        StLocked   = 3'd3,
        StHoldover = 3'd4,
        StFault    = 3'd5
    } state_e;

    // Relock from holdover needs a quarter of the full lock qualification, never zero.
    localparam logic [15:0] RelockTicks = (LOCK_TICKS < 16'd4) ? 16'd1 : (LOCK_TICKS >> 2);

    state_e      state_q, state_d;
    logic [15:0] tick_cnt_q, tick_cnt_d;
    logic [15:0] run_cnt_q, run_cnt_d;
    logic [3:0]  retry_q, retry_d;
    logic [1:0]  sync_q;
    logic        loop_enable_q, vcxo_preset_q, locked_q, fault_q;
    logic        loop_enable_d, vcxo_preset_d, locked_d, fault_d;
    logic        lk;
    logic        take_retry;
    logic [15:0] tick_inc, run_inc;

    assign lk       = ~sync_q[1];
    assign tick_inc = (tick_cnt_q == 16'hFFFF) ? tick_cnt_q : tick_cnt_q + 16'd1;
    assign run_inc  = (run_cnt_q == 16'hFFFF) ? run_cnt_q : run_cnt_q + 16'd1;

    // Two-flop synchroniser for the asynchronous PFD lock flag; resets to "unlocked".
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], lock_n_i};
        end
    end

    // Next-state, counters and retry bookkeeping.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        run_cnt_d  = run_cnt_q;
        retry_d    = retry_q;
        take_retry = 1'b0;
        if (ref_tick_i) begin
            tick_cnt_d = tick_inc;
        end
        case (state_q)
            StIdle: begin
                run_cnt_d = 16'd0;
                state_d   = StPreset;
            end
            StPreset: begin
                run_cnt_d = 16'd0;
                if (ref_tick_i && tick_inc >= PRESET_TICKS) begin
                    state_d = StAcquire;
                end
            end
            StAcquire: begin
                if (ref_tick_i) begin
                    run_cnt_d = lk ? run_inc : 16'd0;
                    // Qualification is tested first so it wins over a coincident timeout.
                    if (lk && run_inc >= LOCK_TICKS) begin
                        state_d = StLocked;
                    end else if (tick_inc >= ACQ_TIMEOUT) begin
                        take_retry = 1'b1;
                    end
                end
            end
            StLocked: begin
                if (ref_tick_i) begin
                    run_cnt_d = lk ? 16'd0 : run_inc;
                    if (!lk && run_inc >= UNLOCK_TICKS) begin
                        state_d = StHoldover;
                    end
                end
            end
            StHoldover: begin
                if (ref_tick_i) begin
                    run_cnt_d = lk ? run_inc : 16'd0;
                    if (lk && run_inc >= RelockTicks) begin
                        state_d = StLocked;
                    end else if (tick_inc >= HOLD_TICKS) begin
                        take_retry = 1'b1;
                    end
                end
            end
            StFault: begin
                run_cnt_d = 16'd0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (take_retry) begin
            if (retry_q == MAX_RETRY) begin
                state_d = StFault;
            end else begin
                retry_d = retry_q + 4'd1;
                state_d = StPreset;
            end
        end

        if (!enable_i) begin
            state_d = StIdle;
        end

        if (state_d != state_q) begin
            tick_cnt_d = 16'd0;
            run_cnt_d  = 16'd0;
            if (state_d == StIdle || state_q == StIdle) begin
                retry_d = 4'd0;
            end
        end
    end

    // Output decode from the next state so registered outputs track state_q exactly.
    always_comb begin
        loop_enable_d = 1'b0;
        vcxo_preset_d = 1'b0;
        locked_d      = 1'b0;
        fault_d       = 1'b0;
        case (state_d)
            StPreset:   vcxo_preset_d = 1'b1;
            StAcquire:  loop_enable_d = 1'b1;
            StLocked: begin
                loop_enable_d = 1'b1;
                locked_d      = 1'b1;
            end
            StHoldover: loop_enable_d = 1'b1;
            StFault: begin
                vcxo_preset_d = 1'b1;
                fault_d       = 1'b1;
            end
            default: ;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            tick_cnt_q    <= 16'd0;
            run_cnt_q     <= 16'd0;
            retry_q       <= 4'd0;
            loop_enable_q <= 1'b0;
            vcxo_preset_q <= 1'b0;
            locked_q      <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            tick_cnt_q    <= tick_cnt_d;
            run_cnt_q     <= run_cnt_d;
            retry_q       <= retry_d;
            loop_enable_q <= loop_enable_d;
            vcxo_preset_q <= vcxo_preset_d;
            locked_q      <= locked_d;
            fault_q       <= fault_d;
        end
    end

    assign state_o       = state_q;
    assign retry_count_o = retry_q;
    assign loop_enable_o = loop_enable_q;
    assign vcxo_preset_o = vcxo_preset_q;
    assign locked_o      = locked_q;
    assign fault_o       = fault_q;

endmodule

// File: tb/tb_pfd_lock_controller.sv
// Scoreboard bench for pfd_lock_controller: a behavioural model predicts every cycle's
// outputs into a queue, a monitor compares on the falling edge, and directed
// scenarios check the tick counts at which transitions occur.
module tb_pfd_lock_controller;

    localparam int PreTicks  = 100;
    localparam int LockTicks = 64;
    localparam int UnlTicks  = 4;
    localparam int AcqTicks  = 2000;
    localparam int HoldTicks = 500;
    localparam int RelTicks  = 16;
    localparam int MaxRetry  = 7;

    logic       clk = 1'b0;
    logic       rst, enable, ref_tick, lock_n;
    logic       loop_enable, vcxo_preset, locked, fault;
    logic [2:0] state;
    logic [3:0] retry_count;

    always #5 clk = ~clk;

    pfd_lock_controller dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .enable_i      (enable),
        .ref_tick_i    (ref_tick),
        .lock_n_i      (lock_n),
        .loop_enable_o (loop_enable),
        .vcxo_preset_o (vcxo_preset),
        .locked_o      (locked),
        .fault_o       (fault),
        .state_o       (state),
        .retry_count_o (retry_count)
    );

    typedef struct packed {
        logic [2:0] st;
        logic       le;
        logic       vp;
        logic       lkd;
        logic       flt;
        logic [3:0] rc;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Behavioural model: mode number, ticks spent in mode, length of current qualifying run.
    int   m_mode, m_ticks, m_run, m_retry;
    logic m_s1, m_s2;

    function automatic obs_t predict();
        obs_t o;
        o.st  = 3'(m_mode);
        o.le  = (m_mode == 2 || m_mode == 3 || m_mode == 4);
        o.vp  = (m_mode == 1 || m_mode == 5);
        o.lkd = (m_mode == 3);
        o.flt = (m_mode == 5);
        o.rc  = 4'(m_retry);
        return o;
    endfunction

    task automatic model_step();
        int  nxt, nt, nr;
        bit  lk, timed_out;
        if (rst) begin
            m_mode = 0; m_ticks = 0; m_run = 0; m_retry = 0; m_s1 = 1'b1; m_s2 = 1'b1;
            return;
        end
        lk = !m_s2;
        m_s2 = m_s1;
        m_s1 = lock_n;
        nxt = m_mode;
        nt = ref_tick ? ((m_ticks < 65535) ? m_ticks + 1 : m_ticks) : m_ticks;
        nr = m_run;
        timed_out = 0;
        if (m_mode == 0) nxt = 1;
        if (ref_tick) begin
            if (m_mode == 1 && nt >= PreTicks) nxt = 2;
            if (m_mode == 2) begin
                nr = lk ? nr + 1 : 0;
                if (nr >= LockTicks) nxt = 3;
                else if (nt >= AcqTicks) timed_out = 1;
            end
            if (m_mode == 3) begin
                nr = lk ? 0 : nr + 1;
                if (nr >= UnlTicks) nxt = 4;
            end
            if (m_mode == 4) begin
                nr = lk ? nr + 1 : 0;
                if (nr >= RelTicks) nxt = 3;
                else if (nt >= HoldTicks) timed_out = 1;
            end
            if (nr > 65535) nr = 65535;
        end
        if (timed_out) begin
            if (m_retry == MaxRetry) nxt = 5;
            else begin m_retry++; nxt = 1; end
        end
        if (!enable) nxt = 0;
        if (nxt != m_mode) begin
            if (nxt == 0 || m_mode == 0) m_retry = 0;
            m_ticks = 0;
            m_run = 0;
        end else begin
            m_ticks = nt;
            m_run = nr;
        end
        m_mode = nxt;
    endtask

    // One clock: model sees the same inputs the DUT samples, prediction queued after the edge.
    task automatic step(input logic tick);
        ref_tick = tick;
        model_step();
        @(posedge clk);
        #1;
        exp_q.push_back(predict());
    endtask

    // Issue one compare tick with the given lock_n; lets a new lock_n settle through the sync.
    task automatic tick_with(input logic ln);
        if (ln !== lock_n) begin
            lock_n = ln;
            step(1'b0);
            step(1'b0);
        end
        if ($urandom_range(0, 3) == 0) step(1'b0);
        step(1'b1);
    endtask

    task automatic run_until(input logic [2:0] target, input logic ln, input int max_ticks,
                             output int used);
        used = 0;
        while (state !== target && used < max_ticks) begin
            tick_with(ln);
            used++;
        end
    endtask

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Monitor: every queued prediction is compared against the DUT away from the clock edge.
    always @(negedge clk) begin
        obs_t e, g;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = {state, loop_enable, vcxo_preset, locked, fault, retry_count};
            n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL outputs @%0t: got st=%0d le=%b vp=%b lk=%b flt=%b rc=%0d, want st=%0d le=%b vp=%b lk=%b flt=%b rc=%0d",
                         $time, g.st, g.le, g.vp, g.lkd, g.flt, g.rc,
                         e.st, e.le, e.vp, e.lkd, e.flt, e.rc);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  used, prev_rc, steps_ok;
        bit  seen_lock;
        logic ln;
        int  len;

        rst = 1'b1; enable = 1'b0; ref_tick = 1'b0; lock_n = 1'b1;
        step(1'b0);
        step(1'b0);
        rst = 1'b0;
        step(1'b0);
        check("reset_state", state, 0);
        check("reset_retry", retry_count, 0);

        // T1: constant lock -> 100 preset ticks, then locked on the 64th acquire tick.
        enable = 1'b1;
        step(1'b0);
        check("t1_enter_preset", state, 1);
        check("t1_preset_vcxo", vcxo_preset, 1);
        run_until(3'd2, 1'b0, PreTicks + 10, used);
        check("t1_preset_ticks", used, PreTicks);
        run_until(3'd3, 1'b0, LockTicks + 10, used);
        check("t1_acquire_ticks", used, LockTicks);
        check("t1_locked", locked, 1);

        // T3: three unlocked ticks are tolerated, four enter holdover, 16 relock.
        repeat (3) tick_with(1'b1);
        tick_with(1'b0);
        check("t3_still_locked", state, 3);
        repeat (3) tick_with(1'b1);
        check("t3_three_unlocked", state, 3);
        tick_with(1'b1);
        check("t3_holdover", state, 4);
        run_until(3'd3, 1'b0, RelTicks + 10, used);
        check("t3_relock_ticks", used, RelTicks);
        check("t3_retry_same", retry_count, 0);

        // T6: toggling lock never qualifies; timeout retry on acquire tick 2000.
        enable = 1'b0;
        step(1'b0);
        check("t6_idle", state, 0);
        enable = 1'b1;
        step(1'b0);
        run_until(3'd2, 1'b0, PreTicks + 10, used);
        check("t6_preset_ticks", used, PreTicks);
        seen_lock = 0;
        for (int i = 1; i <= AcqTicks; i++) begin
            tick_with(i % 2 == 1 ? 1'b1 : 1'b0);
            if (locked) seen_lock = 1;
            if (i == AcqTicks - 1) check("t6_before_timeout", state, 2);
        end
        check("t6_never_locked", seen_lock, 0);
        check("t6_retry_state", state, 1);
        check("t6_retry_count", retry_count, 1);

        // T5: reach holdover with a retry on record, then pulse reset.
        run_until(3'd2, 1'b0, PreTicks + 10, used);
        run_until(3'd3, 1'b0, LockTicks + 10, used);
        check("t5_relock_ticks", used, LockTicks);
        check("t5_retry_kept", retry_count, 1);
        repeat (UnlTicks) tick_with(1'b1);
        check("t5_holdover", state, 4);
        rst = 1'b1;
        step(1'b0);
        rst = 1'b0;
        check("t5_state", state, 0);
        check("t5_outputs", {loop_enable, vcxo_preset, locked, fault}, 0);
        check("t5_retry", retry_count, 0);

        // T4: run of 64 completes on the same tick as the 2000-tick timeout.
        step(1'b0);
        run_until(3'd2, 1'b1, PreTicks + 10, used);
        check("t4_preset_ticks", used, PreTicks);
        repeat (AcqTicks - LockTicks) tick_with(1'b1);
        repeat (LockTicks - 1) tick_with(1'b0);
        check("t4_before", state, 2);
        tick_with(1'b0);
        check("t4_locked", state, 3);
        check("t4_retry", retry_count, 0);

        // T2: never locks -> seven retries then fault; enable low returns to idle.
        enable = 1'b0;
        step(1'b0);
        enable = 1'b1;
        step(1'b0);
        used = 0;
        prev_rc = 0;
        steps_ok = 1;
        while (!fault && used < 8 * (PreTicks + AcqTicks) + 50) begin
            tick_with(1'b1);
            used++;
            if (retry_count != prev_rc) begin
                if (retry_count != prev_rc + 1) steps_ok = 0;
                prev_rc = retry_count;
            end
        end
        check("t2_total_ticks", used, 8 * (PreTicks + AcqTicks));
        check("t2_retry_steps", steps_ok, 1);
        check("t2_retry_count", retry_count, MaxRetry);
        check("t2_fault", {fault, vcxo_preset, loop_enable}, 3'b110);
        repeat (5) tick_with(1'b0);
        check("t2_fault_held", state, 5);
        enable = 1'b0;
        step(1'b0);
        check("t2_idle", state, 0);
        check("t2_idle_retry", retry_count, 0);

        // Randomised segments of lock/unlock with occasional enable drops and resets.
        enable = 1'b1;
        repeat (60) begin
            ln = ($urandom_range(0, 3) != 0) ? 1'b0 : 1'b1;
            len = $urandom_range(1, 80);
            repeat (len) begin
                if ($urandom_range(0, 499) == 0) begin
                    enable = 1'b0;
                    step(1'b0);
                    enable = 1'b1;
                end
                if ($urandom_range(0, 999) == 0) begin
                    rst = 1'b1;
                    step(1'b0);
                    rst = 1'b0;
                end
                if ($urandom_range(0, 9) == 0) lock_n = $urandom_range(0, 1);
                tick_with(ln);
            end
        end

        step(1'b0);
        step(1'b0);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
